// File: rtl/dac80004_pkg.sv
// DAC80004 command codes, sequencer states and frame builder.
// Shared by the sequencer and anything else that talks to the DAC.
package dac80004_pkg;

  localparam logic [3:0] CMD_WR  = 4'b0000;
  localparam logic [3:0] CMD_UPD = 4'b0001;
  localparam logic [3:0] CMD_WRU = 4'b0011;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_INIT  = 3'd0;
  localparam seq_state_t ST_IDLE  = 3'd1;
  localparam seq_state_t ST_ARB   = 3'd2;
  localparam seq_state_t ST_ISSUE = 3'd3;
  localparam seq_state_t ST_WAIT  = 3'd4;
  localparam seq_state_t ST_GAP   = 3'd5;

  function automatic logic [31:0] dac_frame(
    input logic [3:0]  cmd,
    input logic [3:0]  addr,
    input logic [15:0] data
  );
    return {4'h0, cmd, addr, data, 4'h0};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set bit of pending at or after ptr,
// wrapping N-1 -> 0. Purely combinational.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  int j;

  // Scan backwards so the candidate closest to ptr is assigned last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    j = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (pending[j]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dac80004_sequencer.sv
// Setpoint store and frame scheduler in front of the DAC80004
// SPI master: one init frame, then round-robin over dirty channels.
module dac80004_sequencer
  import dac80004_pkg::*;
#(
  parameter int          NCH            = 4,
  parameter logic [31:0] INIT_WORD      = 32'h0,
  parameter int          GAP_CYCLES     = 8,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           wr_en,
  input  logic [1:0]     wr_chan,
  input  logic [15:0]    wr_data,
  input  logic           clr_err,
  output logic           tx_valid,
  output logic [31:0]    tx_data,
  input  logic           tx_ready,
  input  logic           rx_valid,
  input  logic [31:0]    rx_data,
  output logic [31:0]    last_rx,
  output logic [NCH-1:0] pending,
  output logic           busy,
  output logic           timeout_err
);

  localparam int CMAX =
    (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
  localparam seq_state_t RST_STATE =
    (INIT_WORD == 32'h0) ? ST_IDLE : ST_INIT;

  seq_state_t     state;
  seq_state_t     state_nxt;
  logic [CW-1:0]  cnt;
  logic [1:0]     cur_ch;
  logic [1:0]     rr;
  logic           is_init;
  logic [15:0]    setpoint [NCH];
  logic [NCH-1:0] pend_nxt;
  logic [1:0]     grant_idx;
  logic           grant_vld;
  logic [15:0]    grant_sp;
  logic           wr_ok;
  logic           cnt_zero;
  logic           rx_done;
  logic           tmo;
  logic           unused_ok;

  assign unused_ok = tx_ready;

  assign wr_ok    = wr_en && ({30'b0, wr_chan} < 32'(NCH));
  assign cnt_zero = (cnt == '0);
  assign rx_done  = (state == ST_WAIT) && (rx_valid || cnt_zero);
  assign tmo      = (state == ST_WAIT) && !rx_valid && cnt_zero;

  rr_arbiter #(
    .N  (NCH),
    .IW (2)
  ) u_arb (
    .pending   (pending),
    .ptr       (rr),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_comb begin
    grant_sp = '0;
    for (int i = 0; i < NCH; i++)
      if (grant_idx == 2'(i)) grant_sp = setpoint[i];
  end

  // Host write is applied last so it beats the issue clear.
  always_comb begin
    pend_nxt = pending;
    for (int i = 0; i < NCH; i++) begin
      if (state == ST_ARB && grant_vld && grant_idx == 2'(i))
        pend_nxt[i] = 1'b0;
      if (tmo && !is_init && cur_ch == 2'(i))
        pend_nxt[i] = 1'b1;
      if (wr_ok && wr_chan == 2'(i))
        pend_nxt[i] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state == ST_INIT:  state_nxt = ST_ISSUE;
      state == ST_IDLE:  if (|pending) state_nxt = ST_ARB;
      state == ST_ARB:
        state_nxt = grant_vld ? ST_ISSUE : ST_IDLE;
      state == ST_ISSUE: state_nxt = ST_WAIT;
      state == ST_WAIT:  if (rx_done) state_nxt = ST_GAP;
      state == ST_GAP:   if (cnt_zero) state_nxt = ST_IDLE;
      default:           state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RST_STATE;
      cnt         <= '0;
      cur_ch      <= '0;
      rr          <= '0;
      is_init     <= 1'b0;
      pending     <= '0;
      busy        <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      last_rx     <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NCH; i++) setpoint[i] <= '0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != ST_IDLE);
      pending <= pend_nxt;
      for (int i = 0; i < NCH; i++)
        if (wr_ok && wr_chan == 2'(i)) setpoint[i] <= wr_data;
      if (clr_err) timeout_err <= 1'b0;
      if (tmo)     timeout_err <= 1'b1;
      unique case (1'b1)
        state == ST_INIT: begin
          tx_data  <= INIT_WORD;
          tx_valid <= 1'b1;
          is_init  <= 1'b1;
        end
        state == ST_ARB: begin
          if (grant_vld) begin
            cur_ch   <= grant_idx;
            rr       <= (int'(grant_idx) == NCH - 1) ?
                        2'd0 : grant_idx + 2'd1;
            tx_data  <= dac_frame(CMD_WRU, {2'b00, grant_idx},
                                  grant_sp);
            tx_valid <= 1'b1;
            is_init  <= 1'b0;
          end
        end
        state == ST_ISSUE: cnt <= TMO_LOAD;
        state == ST_WAIT: begin
          if (rx_done) begin
            tx_valid <= 1'b0;
            cnt      <= GAP_LOAD;
            if (rx_valid) last_rx <= rx_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        state == ST_GAP: if (!cnt_zero) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dac80004_sequencer.sv
// Directed bench for dac80004_sequencer with a behavioural
// spi_master that answers 40 clk after each tx_valid rise.
module tb_dac80004_sequencer;

  localparam int NCH = 4;
  localparam int GAP = 8;
  localparam int TMO = 4096;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [1:0]  wr_chan;
  logic [15:0] wr_data;
  logic        clr_err;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic [31:0] last_rx;
  logic [3:0]  pending;
  logic        busy;
  logic        timeout_err;

  int cmp = 0;
  int err = 0;

  logic [31:0] frames [$];
  int          gaps [$];
  logic        tv_q = 1'b0;
  int          resp = 0;
  int          low_run = 0;
  logic        mdl_rx = 1'b0;
  logic [31:0] mdl_data = '0;
  logic        respond = 1'b1;
  logic        inj_rx = 1'b0;

  always #5 clk = ~clk;

  dac80004_sequencer #(
    .NCH            (NCH),
    .INIT_WORD      (32'h0900_0000),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_chan     (wr_chan),
    .wr_data     (wr_data),
    .clr_err     (clr_err),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .last_rx     (last_rx),
    .pending     (pending),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  assign rx_valid = mdl_rx | inj_rx;
  assign rx_data  = inj_rx ? 32'hDEAD_BEEF : mdl_data;

  // spi_master stand-in: logs frames and the low time before each
  always @(posedge clk) begin
    tv_q   <= tx_valid;
    mdl_rx <= 1'b0;
    if (tx_valid && !tv_q) begin
      frames.push_back(tx_data);
      gaps.push_back(low_run);
      resp <= 40;
    end else if (resp > 1) begin
      resp <= resp - 1;
    end else if (resp == 1) begin
      resp <= 0;
      if (respond) begin
        mdl_rx   <= 1'b1;
        mdl_data <= ~tx_data;
      end
    end
    low_run <= tx_valid ? 0 : low_run + 1;
  end

  task automatic write(input logic [1:0] ch, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_chan = ch;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while ((busy || pending != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      cmp++;
      err++;
      $display("FAIL wait_idle: busy=%b pending=%b", busy, pending);
    end
  endtask

  task automatic test_reset;
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_chan  = '0;
    wr_data  = '0;
    clr_err  = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    cmp++;
    if (tx_valid !== 1'b0) begin
      err++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid);
    end
    cmp++;
    if (tx_data !== 32'h0) begin
      err++; $display("FAIL rst_tx_data: got %h want 0", tx_data);
    end
    cmp++;
    if (busy !== 1'b0) begin
      err++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    cmp++;
    if (pending !== 4'h0 || timeout_err !== 1'b0) begin
      err++;
      $display("FAIL rst_flags: pend=%b err=%b want 0",
               pending, timeout_err);
    end
    cmp++;
    if (last_rx !== 32'h0) begin
      err++; $display("FAIL rst_last_rx: got %h want 0", last_rx);
    end
  endtask

  task automatic test_init_frame;
    frames.delete();
    gaps.delete();
    reset_n = 1'b1;
    wait_idle(200);
    cmp++;
    if (frames.size() != 1) begin
      err++; $display("FAIL init_count: got %0d want 1", frames.size());
    end else begin
      cmp++;
      if (frames[0] !== 32'h0900_0000) begin
        err++;
        $display("FAIL init_word: got %h want 09000000", frames[0]);
      end
    end
    cmp++;
    if (last_rx !== 32'hF6FF_FFFF) begin
      err++; $display("FAIL init_rx: got %h want f6ffffff", last_rx);
    end
    cmp++;
    if (busy !== 1'b0) begin
      err++; $display("FAIL init_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single_write;
    frames.delete();
    write(2'd2, 16'hABCD);
    cmp++;
    if (pending !== 4'b0100 || tx_valid !== 1'b0) begin
      err++;
      $display("FAIL single_n0: pend=%b txv=%b want 0100/0",
               pending, tx_valid);
    end
    @(negedge clk);
    cmp++;
    if (tx_valid !== 1'b0) begin
      err++; $display("FAIL single_n1: txv=%b want 0", tx_valid);
    end
    @(negedge clk);
    cmp++;
    if (tx_valid !== 1'b1 || tx_data !== 32'h032A_BCD0) begin
      err++;
      $display("FAIL single_frame: txv=%b data=%h want 1/032abcd0",
               tx_valid, tx_data);
    end
    cmp++;
    if (pending !== 4'b0000) begin
      err++; $display("FAIL single_pend: got %b want 0000", pending);
    end
    wait_idle(200);
    cmp++;
    if (last_rx !== 32'hFCD5_432F) begin
      err++; $display("FAIL single_rx: got %h want fcd5432f", last_rx);
    end
  endtask

  task automatic test_back_to_back;
    frames.delete();
    gaps.delete();
    wr_en = 1'b1; wr_chan = 2'd0; wr_data = 16'h1000;
    @(negedge clk);
    wr_chan = 2'd1; wr_data = 16'h2001;
    @(negedge clk);
    wr_chan = 2'd3; wr_data = 16'h3003;
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle(600);
    cmp++;
    if (frames.size() != 3) begin
      err++; $display("FAIL b2b_count: got %0d want 3", frames.size());
    end else begin
      cmp++;
      if (frames[0] !== 32'h0301_0000) begin
        err++; $display("FAIL b2b_f0: got %h want 03010000", frames[0]);
      end
      cmp++;
      if (frames[1] !== 32'h0312_0010) begin
        err++; $display("FAIL b2b_f1: got %h want 03120010", frames[1]);
      end
      cmp++;
      if (frames[2] !== 32'h0333_0030) begin
        err++; $display("FAIL b2b_f2: got %h want 03330030", frames[2]);
      end
      cmp++;
      if (gaps[1] < GAP || gaps[2] < GAP) begin
        err++;
        $display("FAIL b2b_gap: got %0d,%0d want >= %0d",
                 gaps[1], gaps[2], GAP);
      end
    end
  endtask

  task automatic test_last_write_wins;
    frames.delete();
    wr_en = 1'b1; wr_chan = 2'd1; wr_data = 16'h1111;
    @(negedge clk);
    wr_data = 16'h2222;
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle(300);
    cmp++;
    if (frames.size() != 1) begin
      err++; $display("FAIL lww_count: got %0d want 1", frames.size());
    end else begin
      cmp++;
      if (frames[0] !== 32'h0312_2220) begin
        err++; $display("FAIL lww_frame: got %h want 03122220", frames[0]);
      end
    end
  endtask

  task automatic test_write_in_flight;
    int n;
    frames.delete();
    write(2'd1, 16'h4444);
    n = 0;
    while (!tx_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    write(2'd1, 16'h5555);
    cmp++;
    if (pending !== 4'b0010 || tx_valid !== 1'b1) begin
      err++;
      $display("FAIL flight_pend: pend=%b txv=%b want 0010/1",
               pending, tx_valid);
    end
    wait_idle(400);
    cmp++;
    if (frames.size() != 2) begin
      err++; $display("FAIL flight_count: got %0d want 2", frames.size());
    end else begin
      cmp++;
      if (frames[0] !== 32'h0314_4440 || frames[1] !== 32'h0315_5550) begin
        err++;
        $display("FAIL flight_frames: got %h,%h want 03144440,03155550",
                 frames[0], frames[1]);
      end
    end
    cmp++;
    if (last_rx !== 32'hFCEA_AAAF) begin
      err++; $display("FAIL flight_rx: got %h want fceaaaaf", last_rx);
    end
  endtask

  task automatic test_timeout;
    int n;
    int k;
    frames.delete();
    respond = 1'b0;
    write(2'd0, 16'h7777);
    n = 0;
    while (!tx_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    k = 0;
    while (!timeout_err && k < TMO + 100) begin
      @(negedge clk);
      k++;
    end
    cmp++;
    if (k != TMO + 1) begin
      err++; $display("FAIL tmo_cycles: got %0d want %0d", k, TMO + 1);
    end
    cmp++;
    if (tx_valid !== 1'b0 || pending !== 4'b0001) begin
      err++;
      $display("FAIL tmo_retry: txv=%b pend=%b want 0/0001",
               tx_valid, pending);
    end
    respond = 1'b1;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    cmp++;
    if (timeout_err !== 1'b0) begin
      err++; $display("FAIL tmo_clr: got %b want 0", timeout_err);
    end
    wait_idle(300);
    cmp++;
    if (frames.size() != 2) begin
      err++; $display("FAIL tmo_count: got %0d want 2", frames.size());
    end else begin
      cmp++;
      if (frames[1] !== 32'h0307_7770) begin
        err++; $display("FAIL tmo_resend: got %h want 03077770", frames[1]);
      end
    end
    cmp++;
    if (last_rx !== 32'hFCF8_888F) begin
      err++; $display("FAIL tmo_rx: got %h want fcf8888f", last_rx);
    end
  endtask

  task automatic test_stray_rx;
    inj_rx = 1'b1;
    @(negedge clk);
    inj_rx = 1'b0;
    repeat (2) @(negedge clk);
    cmp++;
    if (last_rx !== 32'hFCF8_888F || busy !== 1'b0) begin
      err++;
      $display("FAIL stray_rx: rx=%h busy=%b want fcf8888f/0",
               last_rx, busy);
    end
  endtask

  initial begin
    test_reset();
    test_init_frame();
    test_single_write();
    test_back_to_back();
    test_last_write_wins();
    test_write_in_flight();
    test_timeout();
    test_stray_rx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
